// File: rtl/task_ctrl_pkg.sv
// Shared opcodes, state encoding and width defaults for the task clock run-control block.
package task_ctrl_pkg;

    localparam int CNT_W_DEF  = 32;
    localparam int STEP_W_DEF = 16;

    localparam logic [2:0] OP_HALT   = 3'd0;
    localparam logic [2:0] OP_RUN    = 3'd1;
    localparam logic [2:0] OP_STEP   = 3'd2;
    localparam logic [2:0] OP_SET_BP = 3'd3;
    localparam logic [2:0] OP_CLR_BP = 3'd4;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } task_state_e;

endpackage

// File: rtl/task_clk_ctrl_bp_match.sv
// Breakpoint register plus the increment-compare that flags an advance landing on it.
module bp_match
    import task_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_bp,
    input  logic             clr_bp,
    input  logic [CNT_W-1:0] bp_value,
    input  logic [CNT_W-1:0] count_out,
    input  logic             advance,
    output logic             hit,
    output logic             bp_en
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] bp_reg;
    logic [CNT_W-1:0] count_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            bp_reg <= '0;
            bp_en  <= 1'b0;
        end else if (set_bp) begin
            bp_reg <= bp_value;
            bp_en  <= 1'b1;
        end else if (clr_bp) begin
            bp_en  <= 1'b0;
        end
    end

    // The counter value this advance will produce; wraps naturally at 2^CNT_W.
    assign count_next = count_out + CNT_ONE;
    assign hit        = advance && bp_en && (count_next == bp_reg);

endmodule

// File: rtl/task_clk_ctrl.sv
// Run-control sequencer: HALT/RUN/STEP FSM driving the registered task clock enable.
module task_clk_ctrl
    import task_ctrl_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [CNT_W-1:0]  cmd_arg,
    input  logic [CNT_W-1:0]  count_out,
    output logic              clk_en,
    output logic              halted,
    output logic              bp_hit,
    output logic [STEP_W-1:0] steps_left,
    output task_state_e       state_dbg
);

    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

    // Handshake: a command transfers on any sys_clk edge where cmd_valid && cmd_ready;
    // ready is held high outside reset, so every command takes exactly one cycle.
    task_state_e       state, state_nx;
    logic              clk_en_nx;
    logic              bp_hit_nx;
    logic [STEP_W-1:0] steps_nx;
    logic [STEP_W-1:0] step_n;
    logic              cmd_fire;
    logic              advance;
    logic              hit;
    logic              bp_en;

    assign cmd_ready = !sys_reset;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign step_n    = cmd_arg[STEP_W-1:0];
    assign advance   = (state != ST_HALT) && clk_en;
    assign halted    = (state == ST_HALT);
    assign state_dbg = state;

    bp_match #(
        .CNT_W (CNT_W)
    ) u_bp_match (
        .clk       (sys_clk),
        .reset     (sys_reset),
        .set_bp    (cmd_fire && (cmd_op == OP_SET_BP)),
        .clr_bp    (cmd_fire && (cmd_op == OP_CLR_BP)),
        .bp_value  (cmd_arg),
        .count_out (count_out),
        .advance   (advance),
        .hit       (hit),
        .bp_en     (bp_en)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state      <= ST_HALT;
            clk_en     <= 1'b0;
            bp_hit     <= 1'b0;
            steps_left <= '0;
        end else begin
            state      <= state_nx;
            clk_en     <= clk_en_nx;
            bp_hit     <= bp_hit_nx;
            steps_left <= steps_nx;
        end
    end

    // Priority, lowest first: step countdown, breakpoint hit, then an accepted command.
    always_comb begin
        state_nx  = state;
        clk_en_nx = clk_en;
        steps_nx  = steps_left;
        bp_hit_nx = 1'b0;

        if (state == ST_STEP && clk_en) begin
            steps_nx = steps_left - STEP_ONE;
            if (steps_left == STEP_ONE) begin
                state_nx  = ST_HALT;
                clk_en_nx = 1'b0;
            end
        end

        if (hit) begin
            state_nx  = ST_HALT;
            clk_en_nx = 1'b0;
            steps_nx  = '0;
            bp_hit_nx = 1'b1;
        end

        if (cmd_fire) begin
            case (cmd_op)
                OP_HALT: begin
                    state_nx  = ST_HALT;
                    clk_en_nx = 1'b0;
                    steps_nx  = '0;
                end
                OP_RUN: begin
                    if (state != ST_RUN) begin
                        state_nx  = ST_RUN;
                        clk_en_nx = 1'b1;
                        steps_nx  = '0;
                    end
                end
                OP_STEP: begin
                    if (state == ST_HALT && step_n != '0) begin
                        state_nx  = ST_STEP;
                        clk_en_nx = 1'b1;
                        steps_nx  = step_n;
                    end
                end
                default: ;
            endcase
        end
    end

    logic unused_bp_en;
    assign unused_bp_en = bp_en;

endmodule
